conv3x3_sys_core: RTL and testbench
===================================

CONV3X3_SYS_CORE -- requirements
Module: conv3x3_sys_core

Interface
REQ-001 SHALL have parameter SIZE, default 7, meaning square image edge length in pixels (legal 3..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_load  input  1  image pixel valid strobe.
REQ-005 SHALL have port i_in  input  16 signed  image pixel, raster order.
REQ-006 SHALL have port w_load  input  1  weight valid strobe.
REQ-007 SHALL have port w_in  input  16 signed  filter weight, row-major w[0][0]..w[2][2].
REQ-008 SHALL have port col_out1/col_out2/col_out3  output  16 signed each  bottom-of-chain partial sums for filter columns 0/1/2.
REQ-009 SHALL have port srt_sig  output  1  streaming-active level.
REQ-010 SHALL have port pass  output  1  weight-shift phase indicator.

Function
REQ-011 SHALL contain a 3x3 PE grid: PE(i,j), chain i=1..3 (filter column i-1), depth j=1..3 (filter row j-1).
REQ-012 Each PE SHALL hold weight register W, registered horizontal pass-through (hrzt_out <= hrzt) and registered partial sum P.
REQ-013 When pass=0: P <= vrtc_in + low16(hrzt*W), two's-complement wrap; W holds.
REQ-014 When pass=1: W <= vrtc_in; PE vertical output = W instead of P; pass reaches every PE combinationally in the same cycle.
REQ-015 Chain i top input SHALL be weight-loader output i; col_out(i) = vertical output of PE(i,3).
REQ-016 Stream j SHALL enter PE(1,j); PE(i,j) SHALL receive stream j delayed i-1 cycles.
REQ-017 Weight loader SHALL capture w_in on each cycle w_load=1 into w[0][0]..w[2][2], 4-bit counter.
REQ-018 After the 9th capture, pass SHALL be high exactly 3 cycles starting next cycle, top input i presenting w[2][i-1], w[1][i-1], w[0][i-1] in order; PE(i,j) then holds w[j-1][i-1].
REQ-019 Top inputs SHALL be 0 whenever pass=0; w_load during pass ignored; counter clears after pass phase.
REQ-020 Image loader SHALL store SIZE*SIZE pixels X[r][c] on i_load=1 cycles; i_load ignored while streaming.
REQ-021 Streaming SHALL start the cycle (t0) after the last pixel is captured; srt_sig=1 from t0 for exactly (SIZE-2)*SIZE cycles, then 0 and loader returns to idle.
REQ-022 Sweep r=0..SIZE-3 SHALL occupy SIZE consecutive cycles back-to-back; at cycle t0+r*SIZE+c stream j (before its skew) carries X[r+j-1][c].
REQ-023 Stream j SHALL be output with additional j-1 cycle skew; skewed-in positions and all post-stream cycles carry 0.
REQ-024 Resulting timing: col_out(i) at t0+r*SIZE+c+2i+1 = sum over j of w[j-1][i-1]*X[r+j-1][c+i-1] (mod 2^16).
REQ-025 Weight phase SHALL complete before t0; otherwise products use stale W (no error flag).

Reset
REQ-026 rst_n=0 SHALL immediately clear all W, P, horizontal registers, skew registers, counters, pixel buffer write pointer; col_out1..3=0, srt_sig=0, pass=0.
REQ-027 Reset mid-load, mid-pass or mid-stream SHALL abort the operation; after release the block is idle awaiting new weight and image loads.

Verification
REQ-028 SIZE=7, X[r][c]=10r+c+1, w[0][0]=1 others 0 -> col_out1=1 at t0+3, 2 at t0+4, 11 at t0+10; col_out2=col_out3=0 throughout.
REQ-029 All weights 1, same image -> col_out2=36 at t0+5; col_out3=39 at t0+7.
REQ-030 w[0][0]=300, X[0][0]=300 -> col_out1=24464 at t0+3 (wrap).
REQ-031 9 w_load cycles ending cycle k -> pass=1 cycles k+1..k+3 only, then 0.
REQ-032 srt_sig high exactly 35 cycles from t0 (SIZE=7), then low; outputs return to 0 after pipeline drains.
REQ-033 rst_n asserted mid-stream -> all outputs 0 same cycle; new load after release reproduces REQ-028 values.

Source files
------------

// File: rtl/conv3x3_sys_core.sv
// 3x3 convolution core: weight-stationary 3x3 systolic PE grid, a serial weight
// loader that shifts weights down the chains, and a raster image buffer that streams skewed rows.

module conv3x3_sys_pe (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pass,
    input  logic signed [15:0] hrzt,
    input  logic signed [15:0] vrtc_in,
    output logic signed [15:0] hrzt_out,
    output logic signed [15:0] vrtc_out
);
    logic signed [15:0] w_r;
    logic signed [15:0] p_r;
    logic signed [15:0] hrzt_r;
    logic signed [31:0] prod_s;

    assign prod_s = hrzt * w_r;

    // Weight shift during pass, multiply-accumulate otherwise; pixel always moves right
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r    <= 16'sd0;
            p_r    <= 16'sd0;
            hrzt_r <= 16'sd0;
        end else begin
            hrzt_r <= hrzt;
            if (pass) begin
                w_r <= vrtc_in;
            end else begin
                p_r <= vrtc_in + $signed(prod_s[15:0]);
            end
        end
    end

    assign hrzt_out = hrzt_r;
    assign vrtc_out = pass ? w_r : p_r;
endmodule

module conv3x3_sys_core #(
    parameter int SIZE = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic signed [15:0] i_in,
    input  logic               w_load,
    input  logic signed [15:0] w_in,
    output logic signed [15:0] col_out1,
    output logic signed [15:0] col_out2,
    output logic signed [15:0] col_out3,
    output logic               srt_sig,
    output logic               pass
);
    localparam int NPIX = SIZE * SIZE;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = $clog2(SIZE);

    typedef enum logic [0:0] {WL_COLLECT = 1'b0, WL_PASS = 1'b1} wl_state_t;
    typedef enum logic [0:0] {IM_IDLE = 1'b0, IM_STREAM = 1'b1} im_state_t;

    wl_state_t          wl_state_r, wl_state_s;
    logic [3:0]         w_cnt_r, w_cnt_s;
    logic [1:0]         pass_cnt_r, pass_cnt_s;
    logic               w_cap_s;
    logic signed [15:0] wreg_r [9];
    logic [3:0]         row_base_s;
    logic signed [15:0] top_s [3];

    im_state_t          im_state_r, im_state_s;
    logic [AW-1:0]      wr_ptr_r, wr_ptr_s;
    logic [CW-1:0]      row_r, row_s;
    logic [CW-1:0]      col_r, col_s;
    logic               pix_we_s;
    logic signed [15:0] pix_mem_r [NPIX];
    logic [AW-1:0]      base_s;
    logic signed [15:0] raw_s [3];
    logic signed [15:0] skew1_r, skew2a_r, skew2b_r;

    logic signed [15:0] hrzt_s [3][3];
    logic signed [15:0] vrtc_s [3][4];
    logic signed [15:0] hrzt_unused_s [3];

    // Weight loader next-state: nine captures, then a three-cycle shift phase
    always_comb begin
        wl_state_s = wl_state_r;
        w_cnt_s    = w_cnt_r;
        pass_cnt_s = pass_cnt_r;
        w_cap_s    = 1'b0;
        case (wl_state_r)
            WL_COLLECT: begin
                if (w_load) begin
                    w_cap_s = 1'b1;
                    w_cnt_s = w_cnt_r + 4'd1;
                    if (w_cnt_r == 4'd8) begin
                        wl_state_s = WL_PASS;
                        pass_cnt_s = 2'd0;
                    end else begin
                        wl_state_s = WL_COLLECT;
                    end
                end else begin
                    w_cap_s = 1'b0;
                end
            end
            WL_PASS: begin
                if (pass_cnt_r == 2'd2) begin
                    wl_state_s = WL_COLLECT;
                    w_cnt_s    = 4'd0;
                    pass_cnt_s = 2'd0;
                end else begin
                    pass_cnt_s = pass_cnt_r + 2'd1;
                end
            end
            default: begin
                wl_state_s = WL_COLLECT;
                w_cnt_s    = 4'd0;
                pass_cnt_s = 2'd0;
            end
        endcase
    end

    // Weight loader state, counters and captured weights
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wl_state_r <= WL_COLLECT;
            w_cnt_r    <= 4'd0;
            pass_cnt_r <= 2'd0;
            for (int n = 0; n < 9; n++) begin
                wreg_r[n] <= 16'sd0;
            end
        end else begin
            wl_state_r <= wl_state_s;
            w_cnt_r    <= w_cnt_s;
            pass_cnt_r <= pass_cnt_s;
            if (w_cap_s) begin
                wreg_r[w_cnt_r] <= w_in;
            end
        end
    end

    assign pass = (wl_state_r == WL_PASS);

    // Chain heads shift filter rows bottom-first so row 0 ends up in the top PE
    always_comb begin
        case (pass_cnt_r)
            2'd0:    row_base_s = 4'd6;
            2'd1:    row_base_s = 4'd3;
            2'd2:    row_base_s = 4'd0;
            default: row_base_s = 4'd0;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (pass) begin
                top_s[i] = wreg_r[row_base_s + 4'(i)];
            end else begin
                top_s[i] = 16'sd0;
            end
        end
    end

    // Image loader next-state: fill the frame, then sweep row windows back-to-back
    always_comb begin
        im_state_s = im_state_r;
        wr_ptr_s   = wr_ptr_r;
        row_s      = row_r;
        col_s      = col_r;
        pix_we_s   = 1'b0;
        case (im_state_r)
            IM_IDLE: begin
                if (i_load) begin
                    pix_we_s = 1'b1;
                    if (wr_ptr_r == AW'(NPIX - 1)) begin
                        im_state_s = IM_STREAM;
                        wr_ptr_s   = '0;
                        row_s      = '0;
                        col_s      = '0;
                    end else begin
                        wr_ptr_s = wr_ptr_r + AW'(1'b1);
                    end
                end else begin
                    pix_we_s = 1'b0;
                end
            end
            IM_STREAM: begin
                if (col_r == CW'(SIZE - 1)) begin
                    col_s = '0;
                    if (row_r == CW'(SIZE - 3)) begin
                        im_state_s = IM_IDLE;
                        row_s      = '0;
                    end else begin
                        row_s = row_r + CW'(1'b1);
                    end
                end else begin
                    col_s = col_r + CW'(1'b1);
                end
            end
            default: begin
                im_state_s = IM_IDLE;
                wr_ptr_s   = '0;
                row_s      = '0;
                col_s      = '0;
            end
        endcase
    end

    // Image loader state and sweep counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_state_r <= IM_IDLE;
            wr_ptr_r   <= '0;
            row_r      <= '0;
            col_r      <= '0;
        end else begin
            im_state_r <= im_state_s;
            wr_ptr_r   <= wr_ptr_s;
            row_r      <= row_s;
            col_r      <= col_s;
        end
    end

    // Pixel storage; contents are only read after a complete frame was written
    always_ff @(posedge clk) begin
        if (pix_we_s) begin
            pix_mem_r[wr_ptr_r] <= i_in;
        end
    end

    assign srt_sig = (im_state_r == IM_STREAM);

    // Three vertically adjacent pixels of the current window column
    always_comb begin
        base_s = AW'(row_r) * AW'(SIZE) + AW'(col_r);
        for (int j = 0; j < 3; j++) begin
            if (srt_sig) begin
                raw_s[j] = pix_mem_r[base_s + AW'(j * SIZE)];
            end else begin
                raw_s[j] = 16'sd0;
            end
        end
    end

    // Row j is delayed j extra cycles so it meets the partial sum coming down the chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew1_r  <= 16'sd0;
            skew2a_r <= 16'sd0;
            skew2b_r <= 16'sd0;
        end else begin
            skew1_r  <= raw_s[1];
            skew2a_r <= raw_s[2];
            skew2b_r <= skew2a_r;
        end
    end

    assign hrzt_s[0][0] = raw_s[0];
    assign hrzt_s[0][1] = skew1_r;
    assign hrzt_s[0][2] = skew2b_r;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chain
        assign vrtc_s[gi][0] = top_s[gi];
        for (genvar gj = 0; gj < 3; gj++) begin : g_depth
            logic signed [15:0] h_out_s;
            conv3x3_sys_pe u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .pass     (pass),
                .hrzt     (hrzt_s[gi][gj]),
                .vrtc_in  (vrtc_s[gi][gj]),
                .hrzt_out (h_out_s),
                .vrtc_out (vrtc_s[gi][gj+1])
            );
            if (gi < 2) begin : g_fwd
                assign hrzt_s[gi+1][gj] = h_out_s;
            end else begin : g_last
                assign hrzt_unused_s[gj] = h_out_s;
            end
        end
    end

    assign col_out1 = vrtc_s[0][3];
    assign col_out2 = vrtc_s[1][3];
    assign col_out3 = vrtc_s[2][3];
endmodule

// File: tb/tb_conv3x3_sys_core.sv
// Randomised and directed bench for conv3x3_sys_core against a frame-level convolution model.

module tb_conv3x3_sys_core;
    localparam int SIZE = 7;
    localparam int NPIX = SIZE * SIZE;
    localparam int NOUT = (SIZE - 2) * SIZE;
    localparam int KEND = NOUT + 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_load;
    logic signed [15:0] i_in;
    logic               w_load;
    logic signed [15:0] w_in;
    logic signed [15:0] col_out1, col_out2, col_out3;
    logic               srt_sig;
    logic               pass;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [15:0] wt  [9];
    logic signed [15:0] img [NPIX];

    conv3x3_sys_core #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (i_load),
        .i_in     (i_in),
        .w_load   (w_load),
        .w_in     (w_in),
        .col_out1 (col_out1),
        .col_out2 (col_out2),
        .col_out3 (col_out3),
        .srt_sig  (srt_sig),
        .pass     (pass)
    );

    always #5 clk = ~clk;

    // Filter column i at cycle t0+k: window column entering chain i at stream slot k-i-2
    function automatic logic signed [15:0] model_col(input int i, input int k);
        int s, r, c, acc;
        s   = k - i - 2;
        acc = 0;
        if (s >= 0 && s < NOUT) begin
            r = s / SIZE;
            c = s % SIZE;
            for (int j = 0; j < 3; j++) begin
                acc += int'(wt[j * 3 + i - 1]) * int'(img[(r + j) * SIZE + c]);
            end
        end
        return acc[15:0];
    endfunction

    task automatic set_ramp_image();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                img[r * SIZE + c] = 16'(10 * r + c + 1);
    endtask

    task automatic load_weights();
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            w_load = 1'b1;
            w_in   = wt[n];
        end
        @(negedge clk);
        w_load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic load_image();
        for (int p = 0; p < NPIX; p++) begin
            @(negedge clk);
            i_load = 1'b1;
            i_in   = img[p];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_load = 1'b0; w_load = 1'b0; i_in = 16'sd0; w_in = 16'sd0;
        #1;
        n_cmp++;
        if ({col_out1, col_out2, col_out3, srt_sig, pass} !== '0) begin
            n_err++;
            $display("FAIL reset_hold got %h/%h/%h srt=%b pass=%b want all 0", col_out1, col_out2, col_out3, srt_sig, pass);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({col_out1, col_out2, col_out3, srt_sig, pass} !== '0) begin
            n_err++;
            $display("FAIL reset_idle got %h/%h/%h srt=%b pass=%b want all 0", col_out1, col_out2, col_out3, srt_sig, pass);
        end
    endtask

    task automatic test_single_tap();
        logic signed [15:0] e1, e2, e3, lit;
        for (int n = 0; n < 9; n++) wt[n] = 16'sd0;
        wt[0] = 16'sd1;
        set_ramp_image();
        load_weights();
        load_image();
        for (int k = 0; k <= KEND; k++) begin
            @(negedge clk);
            if (k == 0) i_load = 1'b0;
            e1 = model_col(1, k); e2 = model_col(2, k); e3 = model_col(3, k);
            n_cmp++;
            if ({col_out1, col_out2, col_out3, srt_sig, pass} !== {e1, e2, e3, (k < NOUT), 1'b0}) begin
                n_err++;
                $display("FAIL single_tap k=%0d got %0d/%0d/%0d srt=%b pass=%b want %0d/%0d/%0d srt=%b",
                         k, col_out1, col_out2, col_out3, srt_sig, pass, e1, e2, e3, (k < NOUT));
            end
            if (k == 3 || k == 4 || k == 10) begin
                lit = (k == 3) ? 16'sd1 : ((k == 4) ? 16'sd2 : 16'sd11);
                n_cmp++;
                if (col_out1 !== lit) begin
                    n_err++;
                    $display("FAIL single_tap_const k=%0d got %0d want %0d", k, col_out1, lit);
                end
            end
        end
    endtask

    task automatic test_all_ones();
        logic signed [15:0] e1, e2, e3;
        for (int n = 0; n < 9; n++) wt[n] = 16'sd1;
        set_ramp_image();
        load_weights();
        load_image();
        for (int k = 0; k <= KEND; k++) begin
            @(negedge clk);
            if (k == 0) i_load = 1'b0;
            e1 = model_col(1, k); e2 = model_col(2, k); e3 = model_col(3, k);
            n_cmp++;
            if ({col_out1, col_out2, col_out3, srt_sig} !== {e1, e2, e3, (k < NOUT)}) begin
                n_err++;
                $display("FAIL all_ones k=%0d got %0d/%0d/%0d srt=%b want %0d/%0d/%0d srt=%b",
                         k, col_out1, col_out2, col_out3, srt_sig, e1, e2, e3, (k < NOUT));
            end
            if (k == 5) begin
                n_cmp++;
                if (col_out2 !== 16'sd36) begin
                    n_err++;
                    $display("FAIL all_ones_col2 got %0d want 36", col_out2);
                end
            end
            if (k == 7) begin
                n_cmp++;
                if (col_out3 !== 16'sd39) begin
                    n_err++;
                    $display("FAIL all_ones_col3 got %0d want 39", col_out3);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic signed [15:0] e1, e2, e3;
        for (int n = 0; n < 9; n++) wt[n] = 16'sd0;
        wt[0] = 16'sd300;
        set_ramp_image();
        img[0] = 16'sd300;
        load_weights();
        load_image();
        for (int k = 0; k <= KEND; k++) begin
            @(negedge clk);
            if (k == 0) i_load = 1'b0;
            e1 = model_col(1, k); e2 = model_col(2, k); e3 = model_col(3, k);
            n_cmp++;
            if ({col_out1, col_out2, col_out3} !== {e1, e2, e3}) begin
                n_err++;
                $display("FAIL wrap k=%0d got %0d/%0d/%0d want %0d/%0d/%0d", k, col_out1, col_out2, col_out3, e1, e2, e3);
            end
            if (k == 3) begin
                n_cmp++;
                if (col_out1 !== 16'sd24464) begin
                    n_err++;
                    $display("FAIL wrap_const got %0d want 24464", col_out1);
                end
            end
        end
    endtask

    task automatic test_pass_timing();
        for (int n = 0; n < 9; n++) wt[n] = 16'($urandom);
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            n_cmp++;
            if (pass !== 1'b0) begin
                n_err++;
                $display("FAIL pass_early n=%0d got %b want 0", n, pass);
            end
            w_load = 1'b1;
            w_in   = wt[n];
        end
        for (int m = 1; m <= 5; m++) begin
            @(negedge clk);
            w_load = (m <= 3);
            w_in   = 16'($urandom);
            n_cmp++;
            if (pass !== (m <= 3)) begin
                n_err++;
                $display("FAIL pass_window k+%0d got %b want %b", m, pass, (m <= 3));
            end
        end
    endtask

    task automatic test_random_stream();
        logic signed [15:0] e1, e2, e3;
        for (int p = 0; p < NPIX; p++) img[p] = 16'($urandom);
        load_image();
        for (int k = 0; k <= KEND; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 10) begin
                i_load = 1'b1;
                i_in   = 16'($urandom);
            end else begin
                i_load = 1'b0;
            end
            e1 = model_col(1, k); e2 = model_col(2, k); e3 = model_col(3, k);
            n_cmp++;
            if ({col_out1, col_out2, col_out3, srt_sig} !== {e1, e2, e3, (k < NOUT)}) begin
                n_err++;
                $display("FAIL random k=%0d got %0d/%0d/%0d srt=%b want %0d/%0d/%0d srt=%b",
                         k, col_out1, col_out2, col_out3, srt_sig, e1, e2, e3, (k < NOUT));
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic signed [15:0] e1, e2, e3;
        for (int n = 0; n < 9; n++) wt[n] = 16'sd0;
        wt[0] = 16'sd1;
        set_ramp_image();
        load_weights();
        load_image();
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k == 0) i_load = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({col_out1, col_out2, col_out3, srt_sig, pass} !== '0) begin
            n_err++;
            $display("FAIL reset_mid got %h/%h/%h srt=%b pass=%b want all 0", col_out1, col_out2, col_out3, srt_sig, pass);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_weights();
        load_image();
        for (int k = 0; k <= KEND; k++) begin
            @(negedge clk);
            if (k == 0) i_load = 1'b0;
            e1 = model_col(1, k); e2 = model_col(2, k); e3 = model_col(3, k);
            n_cmp++;
            if ({col_out1, col_out2, col_out3, srt_sig} !== {e1, e2, e3, (k < NOUT)}) begin
                n_err++;
                $display("FAIL after_reset k=%0d got %0d/%0d/%0d srt=%b want %0d/%0d/%0d srt=%b",
                         k, col_out1, col_out2, col_out3, srt_sig, e1, e2, e3, (k < NOUT));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_all_ones();
        test_wrap();
        test_pass_timing();
        test_random_stream();
        test_pass_timing();
        test_random_stream();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
